// File: rtl/hpi_target.sv
// hpi_target: synchronous Host Port Interface target.
// The HPI master and this block share clk; strobes are sampled directly and
// edge-detected against registered copies.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   hpi_addr              register select: 0=DATA 1=MAILBOX 2=ADDRESS 3=STATUS
//   hpi_cs_n/r_n/w_n      active-low chip select, read and write strobes
//   hpi_reset_n           active-low soft reset, same effect as reset
//   hpi_wdata/hpi_rdata   host write data / registered host read data
//   loc_we/addr/wdata     local port into the 512x16 memory
//   loc_rdata             local read data, 1-cycle latency
//   mbx_in_data/full/ack  host-to-local mailbox
//   mbx_out_wr/wdata      local-to-host mailbox post
//   mbx_irq               one-cycle pulse per host mailbox write
module hpi_target (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  hpi_addr,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic        hpi_reset_n,
    input  logic [15:0] hpi_wdata,
    output logic [15:0] hpi_rdata,
    input  logic        loc_we,
    input  logic [8:0]  loc_addr,
    input  logic [15:0] loc_wdata,
    output logic [15:0] loc_rdata,
    output logic [15:0] mbx_in_data,
    output logic        mbx_in_full,
    input  logic        mbx_in_ack,
    input  logic        mbx_out_wr,
    input  logic [15:0] mbx_out_wdata,
    output logic        mbx_irq
);
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_MBX    = 2'd1,
        REG_ADDR   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    logic [15:0] r_mem [0:511];
    logic [15:0] r_mem_q;
    logic [15:0] r_loc_rdata;
    logic        r_prev_cs_n, r_prev_r_n, r_prev_w_n;
    logic        r_wr_block;
    logic [15:0] r_addr;
    logic [15:0] r_mbx_in_data;
    logic [15:0] r_mbx_out;
    logic        r_mbx_in_full, r_mbx_out_full;
    logic        r_irq;
    logic [15:0] r_rdata;

    reg_sel_e    w_sel;
    logic        w_rst, w_wr_evt, w_rd_active, w_rd_end;
    logic        w_in_window, w_host_mem_we;
    logic [8:0]  w_word;
    logic [15:0] w_rd_mux;

    assign w_sel       = reg_sel_e'(hpi_addr);
    assign w_rst       = reset | ~hpi_reset_n;
    assign w_in_window = (r_addr[15:10] == 6'd0);
    assign w_word      = r_addr[9:1];

    // r_wr_block keeps a strobe that is still low after reset from committing;
    // it clears only once the strobe has been seen released.
    assign w_wr_evt    = ~w_rst & ~hpi_cs_n & ~hpi_w_n & hpi_r_n & ~r_wr_block
                         & (r_prev_w_n | r_prev_cs_n);
    assign w_rd_active = ~hpi_cs_n & ~hpi_r_n & hpi_w_n;
    assign w_rd_end    = hpi_r_n & ~r_prev_r_n & ~r_prev_cs_n;

    assign w_host_mem_we = w_wr_evt && (w_sel == REG_DATA) && w_in_window;

    // r_mem_q was fetched on the previous edge, so DATA reads are valid from
    // the second sampled cycle of the strobe.
    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            REG_DATA:   w_rd_mux = w_in_window ? r_mem_q : '0;
            REG_MBX:    w_rd_mux = r_mbx_out;
            REG_ADDR:   w_rd_mux = r_addr;
            REG_STATUS: w_rd_mux = {14'd0, r_mbx_out_full, r_mbx_in_full};
            default:    w_rd_mux = '0;
        endcase
    end

    // Memory is never reset; host write placed last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (loc_we)
            r_mem[loc_addr] <= loc_wdata;
        if (w_host_mem_we)
            r_mem[w_word] <= hpi_wdata;
        r_mem_q     <= r_mem[w_word];
        r_loc_rdata <= r_mem[loc_addr];
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_prev_cs_n    <= 1'b1;
            r_prev_r_n     <= 1'b1;
            r_prev_w_n     <= 1'b1;
            r_wr_block     <= 1'b1;
            r_addr         <= '0;
            r_mbx_in_data  <= '0;
            r_mbx_out      <= '0;
            r_mbx_in_full  <= 1'b0;
            r_mbx_out_full <= 1'b0;
            r_irq          <= 1'b0;
            r_rdata        <= '0;
        end else begin
            r_prev_cs_n <= hpi_cs_n;
            r_prev_r_n  <= hpi_r_n;
            r_prev_w_n  <= hpi_w_n;
            if (hpi_cs_n || hpi_w_n)
                r_wr_block <= 1'b0;

            if (w_wr_evt && w_sel == REG_ADDR)
                r_addr <= hpi_wdata;
            else if ((w_wr_evt || w_rd_end) && w_sel == REG_DATA)
                r_addr <= r_addr + 16'd2;

            r_irq <= w_wr_evt && (w_sel == REG_MBX);
            if (w_wr_evt && w_sel == REG_MBX) begin
                r_mbx_in_data <= hpi_wdata;
                r_mbx_in_full <= 1'b1;
            end else if (mbx_in_ack) begin
                r_mbx_in_full <= 1'b0;
            end

            if (mbx_out_wr) begin
                r_mbx_out      <= mbx_out_wdata;
                r_mbx_out_full <= 1'b1;
            end else if (w_rd_end && w_sel == REG_MBX) begin
                r_mbx_out_full <= 1'b0;
            end

            r_rdata <= w_rd_active ? w_rd_mux : '0;
        end
    end

    assign hpi_rdata   = r_rdata;
    assign loc_rdata   = r_loc_rdata;
    assign mbx_in_data = r_mbx_in_data;
    assign mbx_in_full = r_mbx_in_full;
    assign mbx_irq     = r_irq;

endmodule

// File: tb/tb_hpi_target.sv
// Self-checking bench for hpi_target: directed scenarios followed by a
// randomized operation mix, all compared against a register-level model.
module tb_hpi_target;
    localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;

    logic        clk = 1'b0;
    logic        reset, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_wdata, hpi_rdata;
    logic        loc_we;
    logic [8:0]  loc_addr;
    logic [15:0] loc_wdata, loc_rdata;
    logic [15:0] mbx_in_data;
    logic        mbx_in_full, mbx_in_ack, mbx_out_wr, mbx_irq;
    logic [15:0] mbx_out_wdata;

    always #5 clk = ~clk;

    hpi_target dut (
        .clk(clk), .reset(reset), .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n),
        .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_reset_n(hpi_reset_n),
        .hpi_wdata(hpi_wdata), .hpi_rdata(hpi_rdata), .loc_we(loc_we),
        .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
        .mbx_in_data(mbx_in_data), .mbx_in_full(mbx_in_full), .mbx_in_ack(mbx_in_ack),
        .mbx_out_wr(mbx_out_wr), .mbx_out_wdata(mbx_out_wdata), .mbx_irq(mbx_irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    logic [15:0] m_mem [512];
    logic [15:0] m_addr, m_in_data, m_out;
    logic        m_in_full, m_out_full;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_addr = 16'h0; m_in_data = 16'h0; m_out = 16'h0;
        m_in_full = 1'b0; m_out_full = 1'b0;
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [15:0] d);
        case (a)
            A_DATA: begin
                if (m_addr < 16'h0400) m_mem[m_addr >> 1] = d;
                m_addr = m_addr + 16'd2;
            end
            A_MBX:  begin m_in_data = d; m_in_full = 1'b1; end
            A_ADDR: m_addr = d;
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            A_DATA:  return (m_addr < 16'h0400) ? m_mem[m_addr >> 1] : 16'h0;
            A_MBX:   return m_out;
            A_ADDR:  return m_addr;
            default: return {14'd0, m_out_full, m_in_full};
        endcase
    endfunction

    function automatic void model_read_end(input logic [1:0] a);
        if (a == A_DATA) m_addr = m_addr + 16'd2;
        if (a == A_MBX)  m_out_full = 1'b0;
    endfunction

    // All tasks start and end on a negedge.
    task automatic host_write(input logic [1:0] a, input logic [15:0] d, input int unsigned hold);
        hpi_addr = a; hpi_wdata = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        @(negedge clk);
        check_eq("irq_on_write", {15'd0, mbx_irq}, {15'd0, a == A_MBX});
        repeat (hold - 1) @(negedge clk);
        hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
        @(negedge clk);
        model_write(a, d);
    endtask

    task automatic host_read(input logic [1:0] a, input string tag, output logic [15:0] v);
        logic [15:0] exp;
        exp = model_read(a);
        hpi_addr = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        v = hpi_rdata;
        check_eq(tag, v, exp);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
        @(negedge clk);
        check_eq({tag, "_idle"}, hpi_rdata, 16'h0);
        model_read_end(a);
    endtask

    task automatic loc_write(input logic [8:0] a, input logic [15:0] d);
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        @(negedge clk);
        loc_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic loc_read(input logic [8:0] a, input string tag);
        loc_addr = a;
        @(negedge clk);
        check_eq(tag, loc_rdata, m_mem[a]);
    endtask

    task automatic mbx_ack();
        mbx_in_ack = 1'b1;
        @(negedge clk);
        mbx_in_ack = 1'b0;
        m_in_full = 1'b0;
    endtask

    task automatic mbx_post(input logic [15:0] d);
        mbx_out_wr = 1'b1; mbx_out_wdata = d;
        @(negedge clk);
        mbx_out_wr = 1'b0;
        m_out = d; m_out_full = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] saved0, saved16;

        reset = 1'b1; hpi_reset_n = 1'b1;
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        hpi_addr = A_DATA; hpi_wdata = '0;
        loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
        mbx_in_ack = 1'b0; mbx_out_wr = 1'b0; mbx_out_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_rdata", hpi_rdata, 16'h0);
        check_eq("rst_in_data", mbx_in_data, 16'h0);
        check_eq("rst_in_full", {15'd0, mbx_in_full}, 16'h0);
        check_eq("rst_irq", {15'd0, mbx_irq}, 16'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 512; i++) loc_write(9'(i), 16'($urandom));
        host_read(A_ADDR, "rst_addr", v);
        host_read(A_STAT, "rst_status", v);

        // ADDRESS + two DATA writes
        host_write(A_ADDR, 16'h0010, 1);
        host_write(A_DATA, 16'hAAAA, 1);
        host_write(A_DATA, 16'hBBBB, 1);
        host_read(A_ADDR, "wr_addr", v);
        check_eq("wr_addr_const", v, 16'h0014);
        loc_read(9'd8, "mem8");
        loc_read(9'd9, "mem9");
        check_eq("mem9_const", loc_rdata, 16'hBBBB);

        // Two DATA reads
        host_write(A_ADDR, 16'h0010, 1);
        host_read(A_DATA, "rd0", v);
        check_eq("rd0_const", v, 16'hAAAA);
        host_read(A_DATA, "rd1", v);
        check_eq("rd1_const", v, 16'hBBBB);
        host_read(A_ADDR, "rd_addr", v);
        check_eq("rd_addr_const", v, 16'h0014);

        // Long write strobe commits once
        host_write(A_DATA, 16'hCCCC, 10);
        host_read(A_ADDR, "hold_addr", v);
        check_eq("hold_addr_const", v, 16'h0016);
        loc_read(9'd10, "hold_mem10");
        loc_read(9'd11, "hold_mem11");

        // Host mailbox
        host_write(A_MBX, 16'h1234, 1);
        check_eq("irq_pulse_end", {15'd0, mbx_irq}, 16'h0);
        check_eq("mbx_in_data", mbx_in_data, 16'h1234);
        check_eq("mbx_in_full", {15'd0, mbx_in_full}, 16'h1);
        host_read(A_STAT, "stat_in", v);
        check_eq("stat_in_const", v, 16'h0001);
        mbx_ack();
        host_read(A_STAT, "stat_ack", v);
        check_eq("stat_ack_const", v, 16'h0000);

        // Reply mailbox, then wrap
        mbx_post(16'h5678);
        host_read(A_STAT, "stat_out", v);
        host_read(A_MBX, "mbx_out", v);
        check_eq("mbx_out_const", v, 16'h5678);
        host_read(A_STAT, "stat_out_clr", v);
        host_write(A_ADDR, 16'hFFFE, 1);
        host_read(A_DATA, "oow_read", v);
        host_read(A_ADDR, "wrap_addr", v);
        check_eq("wrap_addr_const", v, 16'h0000);

        // Set-wins collisions on both mailboxes
        hpi_addr = A_MBX; hpi_wdata = 16'h0F0F; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        mbx_in_ack = 1'b1;
        @(negedge clk);
        mbx_in_ack = 1'b0; hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
        @(negedge clk);
        model_write(A_MBX, 16'h0F0F);
        mbx_post(16'h1111);
        hpi_addr = A_MBX; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        repeat (2) @(negedge clk);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
        mbx_out_wr = 1'b1; mbx_out_wdata = 16'h2222;
        @(negedge clk);
        mbx_out_wr = 1'b0; m_out = 16'h2222; m_out_full = 1'b1;
        host_read(A_STAT, "stat_collide", v);
        check_eq("stat_collide_const", v, 16'h0003);

        // Illegal cycle: no read data, no write, no read-end
        host_write(A_ADDR, 16'h0030, 1);
        hpi_addr = A_DATA; hpi_wdata = 16'hEEEE;
        hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("illegal_rdata", hpi_rdata, 16'h0);
        hpi_cs_n = 1'b1;
        @(negedge clk);
        hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        @(negedge clk);
        host_read(A_ADDR, "illegal_addr", v);
        loc_read(9'd24, "illegal_mem");

        // Soft reset coinciding with a DATA write strobe held past release
        host_write(A_ADDR, 16'h0020, 1);
        saved0 = m_mem[0]; saved16 = m_mem[16];
        hpi_addr = A_DATA; hpi_wdata = 16'hDEAD; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        hpi_reset_n = 1'b0;
        @(negedge clk);
        hpi_reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
        @(negedge clk);
        check_eq("srst_in_data", mbx_in_data, 16'h0);
        host_read(A_ADDR, "srst_addr", v);
        check_eq("srst_addr_const", v, 16'h0000);
        host_read(A_STAT, "srst_status", v);
        loc_read(9'd0, "srst_mem0");
        check_eq("srst_mem0_keep", loc_rdata, saved0);
        loc_read(9'd16, "srst_mem16");
        check_eq("srst_mem16_keep", loc_rdata, saved16);

        // Same-word host/local write: host wins
        host_write(A_ADDR, 16'h0040, 1);
        hpi_addr = A_DATA; hpi_wdata = 16'h1111; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        loc_we = 1'b1; loc_addr = 9'd32; loc_wdata = 16'h2222;
        @(negedge clk);
        loc_we = 1'b0; hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
        @(negedge clk);
        m_mem[32] = 16'h2222;
        model_write(A_DATA, 16'h1111);
        loc_read(9'd32, "collide_mem");
        check_eq("collide_mem_const", loc_rdata, 16'h1111);

        // Randomized operation mix
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 10))
                0: begin
                    v = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF));
                    host_write(A_ADDR, v, 1);
                end
                1: host_write(A_DATA, 16'($urandom), $urandom_range(1, 3));
                2: host_read(A_DATA, "r_data", v);
                3: host_write(A_MBX, 16'($urandom), 1);
                4: mbx_ack();
                5: mbx_post(16'($urandom));
                6: host_read(A_MBX, "r_mbx", v);
                7: host_read(A_STAT, "r_stat", v);
                8: loc_write(9'($urandom), 16'($urandom));
                9: loc_read(9'($urandom), "r_loc");
                default: host_read(A_ADDR, "r_addr", v);
            endcase
            check_eq("r_in_full", {15'd0, mbx_in_full}, {15'd0, m_in_full});
            check_eq("r_in_data", mbx_in_data, m_in_data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
